// File: rtl/mult8_result_combiner.sv
// Combines eight 16-bit partial products into packed 8/16/32-bit unsigned products; 1-cycle latency, SEW=32 takes two beats.
// No backpressure: results are registered pulses, always accepted downstream. Optional macro MULT8_COMB_OVF_EN adds out_ovf.
module mult8_result_combiner #(
  parameter int P_W   = 16,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       sew,
  input  logic             count_0,
  input  logic [P_W-1:0]   p1,
  input  logic [P_W-1:0]   p2,
  input  logic [P_W-1:0]   p3,
  input  logic [P_W-1:0]   p4,
  input  logic [P_W-1:0]   p5,
  input  logic [P_W-1:0]   p6,
  input  logic [P_W-1:0]   p7,
  input  logic [P_W-1:0]   p8,
  output logic             out_valid,
  output logic [1:0]       out_sew,
  output logic [OUT_W-1:0] out_result,
  output logic             err
`ifdef MULT8_COMB_OVF_EN
  ,
  output logic [3:0]       out_ovf
`endif
);

  localparam int H_W = 2 * P_W;

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] acc;
  logic             load_acc;
  logic             emit;
  logic             err_nxt;
  logic [OUT_W-1:0] res_nxt;

  logic [H_W-1:0]   elem0, elem1;
  logic [OUT_W-1:0] res_sew8, res_sew16, beat_sum, res_sew32;

  function automatic logic [H_W-1:0] ext_h(input logic [P_W-1:0] p);
    return {{(H_W-P_W){1'b0}}, p};
  endfunction

  function automatic logic [OUT_W-1:0] ext_w(input logic [P_W-1:0] p);
    return {{(OUT_W-P_W){1'b0}}, p};
  endfunction

  // Cross terms are summed before shifting so each element stays exact in 2*P_W bits.
  assign elem0     = ext_h(p1) + ((ext_h(p5) + ext_h(p6)) << 8) + (ext_h(p2) << 16);
  assign elem1     = ext_h(p3) + ((ext_h(p7) + ext_h(p8)) << 8) + (ext_h(p4) << 16);
  assign res_sew8  = {p4, p3, p2, p1};
  assign res_sew16 = {elem1, elem0};

  assign beat_sum  = ext_w(p1)
                   + (ext_w(p2) << 8)
                   + (ext_w(p3) << 16)
                   + (ext_w(p4) << 24)
                   + (ext_w(p5) << 8)
                   + (ext_w(p6) << 16)
                   + (ext_w(p7) << 24)
                   + (ext_w(p8) << 32);
  assign res_sew32 = acc + (beat_sum << 16);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_acc  = 1'b0;
    emit      = 1'b0;
    err_nxt   = 1'b0;
    res_nxt   = '0;
    if (in_valid) begin
      if (sew == 2'b11) begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            case (sew)
              2'b00: begin
                emit    = 1'b1;
                res_nxt = res_sew8;
              end
              2'b01: begin
                emit    = 1'b1;
                res_nxt = res_sew16;
              end
              default: begin
                if (count_0) begin
                  err_nxt = 1'b1;
                end else begin
                  load_acc  = 1'b1;
                  state_nxt = ACC;
                end
              end
            endcase
          end
          ACC: begin
            if (sew == 2'b10 && count_0) begin
              emit      = 1'b1;
              res_nxt   = res_sew32;
              state_nxt = IDLE;
            end else if (sew == 2'b10) begin
              // A new first beat restarts the accumulation after flagging the lost element.
              err_nxt   = 1'b1;
              load_acc  = 1'b1;
              state_nxt = ACC;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load_acc) begin
      acc <= beat_sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sew    <= 2'b00;
      out_result <= '0;
      err        <= 1'b0;
    end else begin
      out_valid <= emit;
      err       <= err_nxt;
      if (emit) begin
        out_sew    <= sew;
        out_result <= res_nxt;
      end
    end
  end

`ifdef MULT8_COMB_OVF_EN
  logic [3:0] ovf_nxt;

  always_comb begin
    ovf_nxt = '0;
    case (sew)
      2'b00: begin
        for (int i = 0; i < 4; i++) begin
          ovf_nxt[i] = |res_nxt[P_W*i + P_W/2 +: P_W/2];
        end
      end
      2'b01: begin
        ovf_nxt[0] = |res_nxt[H_W-1:P_W];
        ovf_nxt[1] = |res_nxt[OUT_W-1:OUT_W-P_W];
      end
      2'b10:   ovf_nxt[0] = |res_nxt[OUT_W-1:OUT_W/2];
      default: ovf_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_ovf <= '0;
    end else if (emit) begin
      out_ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mult8_result_combiner.sv
// Bench for mult8_result_combiner: operand-level reference model plus literal checks of the key products.
module tb_mult8_result_combiner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  sew = 2'b00;
  logic        count_0 = 1'b0;
  logic [15:0] p1 = '0, p2 = '0, p3 = '0, p4 = '0, p5 = '0, p6 = '0, p7 = '0, p8 = '0;
  logic        out_valid;
  logic [1:0]  out_sew;
  logic [63:0] out_result;
  logic        err;
`ifdef MULT8_COMB_OVF_EN
  logic [3:0]  out_ovf;
  logic [3:0]  m_ovf = '0;
`endif

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  logic [31:0] cur_a = '0, cur_b = '0;
  logic        m_valid = 1'b0, m_err = 1'b0, m_pend = 1'b0;
  logic [1:0]  m_sew = 2'b00;
  logic [63:0] m_result = '0;

  mult8_result_combiner dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sew(sew), .count_0(count_0),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .out_valid(out_valid), .out_sew(out_sew), .out_result(out_result), .err(err)
`ifdef MULT8_COMB_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference products straight from the operands.
  function automatic logic [63:0] lanes8(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = 16'(a[8*i +: 8]) * 16'(b[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [63:0] lanes16(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r[31:0]  = 32'(a[15:0]) * 32'(b[15:0]);
    r[63:32] = 32'(a[31:16]) * 32'(b[31:16]);
    return r;
  endfunction

  function automatic logic [63:0] prod32(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

`ifdef MULT8_COMB_OVF_EN
  function automatic logic [3:0] ovf_of(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [3:0] o = '0;
    if (s == 2'b00) begin
      for (int i = 0; i < 4; i++) o[i] = (16'(a[8*i +: 8]) * 16'(b[8*i +: 8])) > 16'd255;
    end else if (s == 2'b01) begin
      o[0] = (32'(a[15:0]) * 32'(b[15:0])) > 32'hFFFF;
      o[1] = (32'(a[31:16]) * 32'(b[31:16])) > 32'hFFFF;
    end else begin
      o[0] = prod32(a, b) > 64'hFFFF_FFFF;
    end
    return o;
  endfunction
`endif

  // Operand-level model: a pending first beat is the only state.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_err    <= 1'b0;
      m_pend   <= 1'b0;
      m_sew    <= 2'b00;
      m_result <= '0;
`ifdef MULT8_COMB_OVF_EN
      m_ovf    <= '0;
`endif
    end else begin
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      if (in_valid) begin
        if (sew == 2'b11) begin
          m_err  <= 1'b1;
          m_pend <= 1'b0;
        end else if (m_pend) begin
          if (sew == 2'b10 && count_0) begin
            m_valid  <= 1'b1;
            m_sew    <= sew;
            m_result <= prod32(cur_a, cur_b);
`ifdef MULT8_COMB_OVF_EN
            m_ovf    <= ovf_of(sew, cur_a, cur_b);
`endif
            m_pend   <= 1'b0;
          end else begin
            m_err  <= 1'b1;
            m_pend <= (sew == 2'b10) && !count_0;
          end
        end else if (sew == 2'b10) begin
          if (count_0) m_err <= 1'b1;
          else         m_pend <= 1'b1;
        end else begin
          m_valid  <= 1'b1;
          m_sew    <= sew;
          m_result <= (sew == 2'b00) ? lanes8(cur_a, cur_b) : lanes16(cur_a, cur_b);
`ifdef MULT8_COMB_OVF_EN
          m_ovf    <= ovf_of(sew, cur_a, cur_b);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model out_valid", 64'(out_valid), 64'(m_valid));
      check("model err", 64'(err), 64'(m_err));
      check("model out_sew", 64'(out_sew), 64'(m_sew));
      check("model out_result", out_result, m_result);
`ifdef MULT8_COMB_OVF_EN
      check("model out_ovf", 64'(out_ovf), 64'(m_ovf));
`endif
    end
  end

  // Router behaviour: split operands into the partial products each SEW expects.
  task automatic beat(input logic [1:0] s, input logic c, input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ab [4];
    logic [7:0]  bb [4];
    logic [15:0] pp [8];
    int lo;
    for (int i = 0; i < 4; i++) begin
      ab[i] = a[8*i +: 8];
      bb[i] = b[8*i +: 8];
    end
    for (int i = 0; i < 8; i++) pp[i] = '0;
    case (s)
      2'b00: for (int i = 0; i < 4; i++) pp[i] = 16'(ab[i]) * 16'(bb[i]);
      2'b01: begin
        pp[0] = 16'(ab[0]) * 16'(bb[0]);  pp[1] = 16'(ab[1]) * 16'(bb[1]);
        pp[4] = 16'(ab[1]) * 16'(bb[0]);  pp[5] = 16'(ab[0]) * 16'(bb[1]);
        pp[2] = 16'(ab[2]) * 16'(bb[2]);  pp[3] = 16'(ab[3]) * 16'(bb[3]);
        pp[6] = 16'(ab[3]) * 16'(bb[2]);  pp[7] = 16'(ab[2]) * 16'(bb[3]);
      end
      2'b10: begin
        lo = c ? 2 : 0;
        for (int k = 0; k < 4; k++) begin
          pp[k]     = 16'(ab[k]) * 16'(bb[lo]);
          pp[k + 4] = 16'(ab[k]) * 16'(bb[lo + 1]);
        end
      end
      default: for (int i = 0; i < 8; i++) pp[i] = a[15:0] ^ 16'(i);
    endcase
    cur_a = a; cur_b = b;
    p1 = pp[0]; p2 = pp[1]; p3 = pp[2]; p4 = pp[3];
    p5 = pp[4]; p6 = pp[5]; p7 = pp[6]; p8 = pp[7];
    sew = s; count_0 = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sew = 2'b00; count_0 = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0; p5 = '0; p6 = '0; p7 = '0; p8 = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] va [5] = '{32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h00FF_0F01};
  logic [31:0] vb [5] = '{32'h9ABC_DEF0, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0000_0001, 32'hFF00_10FF};

  initial begin
    #2 reset = 1'b1;
    armed = 1'b1;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset out_sew", 64'(out_sew), 64'd0);
    check("reset out_result", out_result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    beat(2'b00, 1'b0, 32'h0403_0201, 32'h0505_0505);
    check("sew8 valid", 64'(out_valid), 64'd1);
    check("sew8 result", out_result, 64'h0014_000F_000A_0005);
`ifdef MULT8_COMB_OVF_EN
    check("sew8 ovf", 64'(out_ovf), 64'd0);
`endif
    idle(1);
    check("hold valid", 64'(out_valid), 64'd0);
    check("hold result", out_result, 64'h0014_000F_000A_0005);

    beat(2'b01, 1'b0, 32'hFFFF_0100, 32'hFFFF_0100);
    check("sew16 result", out_result, 64'hFFFE_0001_0001_0000);
    check("sew16 sew", 64'(out_sew), 64'd1);
`ifdef MULT8_COMB_OVF_EN
    check("sew16 ovf", 64'(out_ovf), 64'h3);
`endif

    beat(2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("sew32 beat0 no output", 64'(out_valid), 64'd0);
    beat(2'b10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("sew32 valid", 64'(out_valid), 64'd1);
    check("sew32 result", out_result, 64'hFFFF_FFFE_0000_0001);
`ifdef MULT8_COMB_OVF_EN
    check("sew32 ovf", 64'(out_ovf), 64'h1);
`endif

    beat(2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(2);
    check("sew32 gap no output", 64'(out_valid), 64'd0);
    beat(2'b10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("sew32 gap result", out_result, 64'hFFFF_FFFE_0000_0001);

    beat(2'b10, 1'b1, 32'h1111_1111, 32'h2222_2222);
    check("orphan err", 64'(err), 64'd1);
    check("orphan no valid", 64'(out_valid), 64'd0);
    idle(1);
    check("err one cycle", 64'(err), 64'd0);

    beat(2'b10, 1'b0, 32'h0000_0007, 32'h0000_0009);
    beat(2'b00, 1'b0, 32'h0101_0101, 32'h0202_0202);
    check("abort err", 64'(err), 64'd1);
    check("abort no valid", 64'(out_valid), 64'd0);
    beat(2'b00, 1'b0, 32'h0101_0101, 32'h0202_0202);
    check("after abort result", out_result, 64'h0002_0002_0002_0002);

    beat(2'b10, 1'b0, 32'h0000_0009, 32'h0000_0009);
    beat(2'b10, 1'b0, 32'h0000_0003, 32'h0000_0005);
    check("restart err", 64'(err), 64'd1);
    beat(2'b10, 1'b1, 32'h0000_0003, 32'h0000_0005);
    check("restart result", out_result, 64'h0000_0000_0000_000F);

    beat(2'b10, 1'b0, 32'h0000_0003, 32'h0000_0005);
    beat(2'b11, 1'b0, 32'h0000_0003, 32'h0000_0005);
    check("sew11 err", 64'(err), 64'd1);
    beat(2'b10, 1'b1, 32'h0000_0003, 32'h0000_0005);
    check("sew11 then orphan", 64'(err), 64'd1);

    beat(2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    reset = 1'b1;
    #1;
    check("mid reset valid", 64'(out_valid), 64'd0);
    check("mid reset result", out_result, 64'd0);
    check("mid reset sew", 64'(out_sew), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    beat(2'b10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("post reset orphan err", 64'(err), 64'd1);
    check("post reset no valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 5; i++) begin
      beat(2'b00, 1'b0, va[i], vb[i]);
      beat(2'b01, 1'b0, va[i], vb[i]);
      beat(2'b10, 1'b0, va[i], vb[i]);
      beat(2'b10, 1'b1, va[i], vb[i]);
      idle(1);
    end
    beat(2'b10, 1'b0, va[0], vb[0]);
    idle(1);
    beat(2'b10, 1'b1, va[0], vb[0]);
    check("table tail result", out_result, 64'h0B00_EA4E_242D_2080);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
